mult_unit: RTL and testbench

MULT_UNIT -- requirements
Module: mult_unit

---
 rtl/mult_unit_pkg.sv | 13 +
 rtl/mult_unit_step.sv | 22 ++
 rtl/mult_unit.sv | 91 +++++++++
 tb/tb_mult_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mult_unit_pkg.sv
// Shared CPU definitions for the iterative multiplier: FSM state encoding and width constants.
package mult_unit_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } multState_t;

endpackage

// File: rtl/mult_unit_step.sv
// Single combinational shift-add step of the unsigned magnitude multiplier.
module mult_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] accIn,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] accOut,
  output logic [WIDTH-1:0]   mplierOut
);

  logic [WIDTH:0] sum;

  // NOTE: every combinational output is assigned on every path, so no latch can be inferred.
  always_comb begin
    sum       = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    // The add carry lands in the accumulator MSB as the whole thing shifts right.
    accOut    = {sum, accIn[WIDTH-1:1]};
    mplierOut = {1'b0, mplier[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_unit.sv
// Iterative WIDTH-cycle shift-add multiplier (MULT/MULTU) with hi/lo result registers.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  multState_t         state, nextState;
  logic [2*WIDTH-1:0] acc, stepAcc;
  logic [WIDTH-1:0]   mcand, mplier, stepMplier;
  logic [CNT_W-1:0]   cnt;
  logic               resSign;
  logic               accept, lastStep;
  logic               negA, negB;
  logic [WIDTH-1:0]   magA, magB;

  assign accept   = start && (state != RUN);
  assign lastStep = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign negA     = op_signed && dataA[WIDTH-1];
  assign negB     = op_signed && dataB[WIDTH-1];
  // Negating the most negative value wraps back to itself, which is its correct unsigned magnitude.
  assign magA     = negA ? -dataA : dataA;
  assign magB     = negB ? -dataB : dataB;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .accIn     (acc),
    .mcand     (mcand),
    .mplier    (mplier),
    .accOut    (stepAcc),
    .mplierOut (stepMplier)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start) nextState = RUN;
      RUN:     if (lastStep) nextState = DONE;
      DONE:    nextState = start ? RUN : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      resSign <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (accept) begin
      acc     <= '0;
      mcand   <= magA;
      mplier  <= magB;
      cnt     <= '0;
      resSign <= negA ^ negB;
    end else if (state == RUN) begin
      acc    <= stepAcc;
      mplier <= stepMplier;
      cnt    <= cnt + 1'b1;
      // The final step's result goes straight to hi/lo as DONE is entered.
      if (lastStep) {hi, lo} <= resSign ? -stepAcc : stepAcc;
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: directed vectors, reset abort and back-to-back starts.
module tb_mult_unit;

  localparam int W = 32;

  logic         clk, rst_n, start, op_signed;
  logic [W-1:0] dataA, dataB, hi, lo;
  logic         busy, done;

  mult_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_signed (op_signed),
    .dataA     (dataA),
    .dataB     (dataB),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] prod;
    int          acceptEdge;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   nChecks = 0;
  int   nErrors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("FAIL unexpected_done: done=1 with no outstanding request at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_product"}, {hi, lo}, e.prod);
        check({e.name, "_latency"}, 64'(cyc - e.acceptEdge), 64'(W));
      end
    end
  end

  task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic push, input logic [63:0] exp);
    exp_t e;
    start     = 1'b1;
    dataA     = a;
    dataB     = b;
    op_signed = s;
    if (push) begin
      e.prod       = exp;
      e.acceptEdge = cyc + 1;
      e.name       = name;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, output int busyCycles);
    bit seen = 0;
    busyCycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (busy === 1'b1) busyCycles++;
      @(negedge clk);
    end
    if (!seen) begin
      nChecks++;
      nErrors++;
      $display("FAIL %s_timeout: done=0 after 100 cycles, expected done=1", name);
    end
  endtask

  task automatic runOne(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [63:0] exp);
    int n;
    issue(name, a, b, s, 1'b1, exp);
    waitDone(name, n);
    check({name, "_busy_cycles"}, 64'(n), 64'(W));
    @(negedge clk);
    check({name, "_done_pulse"}, 64'(done), 64'(0));
    repeat (3) @(negedge clk);
    check({name, "_hold"}, {hi, lo}, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; op_signed = 1'b0; dataA = '0; dataB = '0;
    @(negedge clk);
    // start held high during reset must be ignored
    start = 1'b1; dataA = 32'd5; dataB = 32'd5;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_hilo", {hi, lo}, 64'h0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("start_in_reset_ignored", 64'(busy), 64'(0));

    runOne("multu_3x5",   32'd3,          32'd5,          1'b0, 64'h00000000_0000000F);
    runOne("multu_max",   32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'hFFFFFFFE_00000001);
    runOne("mult_m2x3",   32'hFFFFFFFE,   32'h00000003,   1'b1, 64'hFFFFFFFF_FFFFFFFA);
    runOne("multu_m2x3",  32'hFFFFFFFE,   32'h00000003,   1'b0, 64'h00000002_FFFFFFFA);
    runOne("mult_minmin", 32'h80000000,   32'h80000000,   1'b1, 64'h40000000_00000000);
    runOne("mult_maxneg", 32'h7FFFFFFF,   32'hFFFFFFFF,   1'b1, 64'hFFFFFFFF_80000001);
    runOne("multu_zero",  32'h00000000,   32'h00001234,   1'b0, 64'h0);
    runOne("mult_6x7",    32'd6,          32'd7,          1'b1, 64'd42);

    // Reset mid-run: aborted 7*9 must produce no done and must clear hi/lo.
    issue("abort_7x9", 32'd7, 32'd9, 1'b0, 1'b0, 64'h0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_hilo", {hi, lo}, 64'h0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    runOne("after_abort_2x2", 32'd2, 32'd2, 1'b0, 64'd4);

    // Back-to-back: 6*6 during RUN is ignored, 2*3 issued while done=1.
    issue("b2b_4x4", 32'd4, 32'd4, 1'b0, 1'b1, 64'd16);
    repeat (4) @(negedge clk);
    issue("ignored_6x6", 32'd6, 32'd6, 1'b0, 1'b0, 64'h0);
    waitDone("b2b_4x4", n);
    issue("b2b_2x3", 32'd2, 32'd3, 1'b0, 1'b1, 64'd6);
    check("b2b_done_falls", 64'(done), 64'(0));
    check("b2b_no_idle", 64'(busy), 64'(1));
    check("b2b_hold_during_run", {hi, lo}, 64'd16);
    waitDone("b2b_2x3", n);
    check("b2b_busy_cycles", 64'(n), 64'(W));
    repeat (40) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
